// File: rtl/name_entry_ctrl.sv
// name_entry_ctrl
// Keyboard-driven write sequencer for the 8-character team-name buffer.
// Converts HID keycodes to 7-bit ASCII and drives the buffer write port,
// tracking length, backspace, clear and lock state. After reset (and on
// Escape) it writes CLR_CHAR to every address so the buffer never relies
// on its own reset.
//
// Ports:
//   Clk        in   system clock
//   Reset      in   synchronous, active-high reset
//   keycode    in   [7:0] HID keycode (level), 8'h00 = no key
//   name_we    out  buffer write enable, one cycle per write
//   name_addr  out  [2:0] buffer write address
//   name_data  out  [6:0] ASCII character to write
//   length     out  [3:0] characters entered, 0..8
//   full       out  length == 8 (decoded)
//   locked     out  name confirmed by Enter
//   busy       out  clear sequence in progress (decoded)

module name_entry_ctrl #(
   parameter int unsigned NAME_LEN = 8,
   parameter logic [6:0]  CLR_CHAR = 7'h00
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [7:0] keycode,
   output logic       name_we,
   output logic [2:0] name_addr,
   output logic [6:0] name_data,
   output logic [3:0] length,
   output logic       full,
   output logic       locked,
   output logic       busy
);

   localparam int unsigned ADDR_W = 3;
   localparam int unsigned LEN_W  = 4;
   localparam int unsigned CHAR_W = 7;
   localparam int unsigned KC_W   = 8;

   localparam logic [KC_W-1:0] KC_ENTER = 8'h28;
   localparam logic [KC_W-1:0] KC_ESC   = 8'h29;
   localparam logic [KC_W-1:0] KC_BKSP  = 8'h2A;

   typedef enum logic [1:0] {
      S_CLEAR  = 2'd0,
      S_IDLE   = 2'd1,
      S_LOCKED = 2'd2
   } state_t;

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   clr_cnt, clr_cnt_nxt;
   logic [KC_W-1:0]     kc_prev;
   logic                we_nxt;
   logic [ADDR_W-1:0]   addr_nxt;
   logic [CHAR_W-1:0]   data_nxt;
   logic [LEN_W-1:0]    len_nxt;
   logic                locked_nxt;

   logic                press_c;
   logic                is_print_c;
   logic [CHAR_W-1:0]   char_c;
   logic                clr_done_c;

   // Rising edge of "any key": a held key yields exactly one press.
   assign press_c = (kc_prev == '0) && (keycode != '0);

   // The clear is finished once the write to the last address is on the port.
   assign clr_done_c = name_we && (name_addr == ADDR_W'(NAME_LEN - 1));

   assign full = (length == LEN_W'(NAME_LEN));
   assign busy = (state == S_CLEAR);

   // HID keycode to ASCII for the printable subset.
   always_comb begin
      is_print_c = 1'b0;
      char_c     = '0;
      if (keycode >= 8'h04 && keycode <= 8'h1D) begin
         is_print_c = 1'b1;
         char_c     = CHAR_W'(keycode + 8'h5D);
      end else if (keycode >= 8'h1E && keycode <= 8'h26) begin
         is_print_c = 1'b1;
         char_c     = CHAR_W'(keycode + 8'h13);
      end else if (keycode == 8'h27) begin
         is_print_c = 1'b1;
         char_c     = 7'h30;
      end else if (keycode == 8'h2C) begin
         is_print_c = 1'b1;
         char_c     = 7'h20;
      end
   end

   // State and output registers; kc_prev tracks keycode even in reset.
   always_ff @(posedge Clk) begin
      kc_prev <= keycode;
      if (Reset) begin
         state     <= S_CLEAR;
         clr_cnt   <= '0;
         name_we   <= 1'b0;
         name_addr <= '0;
         name_data <= '0;
         length    <= '0;
         locked    <= 1'b0;
      end else begin
         state     <= state_nxt;
         clr_cnt   <= clr_cnt_nxt;
         name_we   <= we_nxt;
         name_addr <= addr_nxt;
         name_data <= data_nxt;
         length    <= len_nxt;
         locked    <= locked_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         S_CLEAR: begin
            if (clr_done_c) state_nxt = S_IDLE;
         end
         S_IDLE: begin
            if (press_c) begin
               if (keycode == KC_ESC)
                  state_nxt = S_CLEAR;
               else if (keycode == KC_ENTER && length != '0)
                  state_nxt = S_LOCKED;
            end
         end
         S_LOCKED: begin
            if (press_c && keycode == KC_ESC) state_nxt = S_CLEAR;
         end
         default: state_nxt = S_CLEAR;
      endcase
   end

   // Next values of the registered outputs and the clear counter.
   always_comb begin
      we_nxt      = 1'b0;
      addr_nxt    = name_addr;
      data_nxt    = name_data;
      len_nxt     = length;
      locked_nxt  = locked;
      clr_cnt_nxt = clr_cnt;
      case (state)
         S_CLEAR: begin
            if (clr_done_c) begin
               len_nxt     = '0;
               locked_nxt  = 1'b0;
               clr_cnt_nxt = '0;
            end else begin
               we_nxt      = 1'b1;
               addr_nxt    = clr_cnt;
               data_nxt    = CLR_CHAR;
               clr_cnt_nxt = clr_cnt + ADDR_W'(1);
            end
         end
         S_IDLE: begin
            if (press_c) begin
               if (is_print_c) begin
                  if (length < LEN_W'(NAME_LEN)) begin
                     we_nxt   = 1'b1;
                     addr_nxt = ADDR_W'(length);
                     data_nxt = char_c;
                     len_nxt  = length + LEN_W'(1);
                  end
               end else if (keycode == KC_BKSP) begin
                  if (length != '0) begin
                     we_nxt   = 1'b1;
                     addr_nxt = ADDR_W'(length - LEN_W'(1));
                     data_nxt = CLR_CHAR;
                     len_nxt  = length - LEN_W'(1);
                  end
               end else if (keycode == KC_ENTER) begin
                  if (length != '0) locked_nxt = 1'b1;
               end else if (keycode == KC_ESC) begin
                  clr_cnt_nxt = '0;
               end
            end
         end
         S_LOCKED: begin
            // locked stays set through the clear; it drops when the clear ends.
            if (press_c && keycode == KC_ESC) clr_cnt_nxt = '0;
         end
         default: begin
            clr_cnt_nxt = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_name_entry_ctrl.sv
// Self-checking bench for name_entry_ctrl: directed keycode sequences with
// hand-computed expected write-port and status values.

module tb_name_entry_ctrl;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic [7:0] keycode = 8'h00;
   logic       name_we;
   logic [2:0] name_addr;
   logic [6:0] name_data;
   logic [3:0] length;
   logic       full;
   logic       locked;
   logic       busy;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 Clk = ~Clk;

   name_entry_ctrl dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .keycode   (keycode),
      .name_we   (name_we),
      .name_addr (name_addr),
      .name_data (name_data),
      .length    (length),
      .full      (full),
      .locked    (locked),
      .busy      (busy)
   );

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      Reset = 1'b1; keycode = 8'h00;
      step(); step();
      n_checks++;
      if ({name_we, name_addr, name_data, length, locked, busy, full} !== {1'b0, 3'd0, 7'h00, 4'd0, 1'b0, 1'b1, 1'b0})
         $display("FAIL reset_state: got we=%b addr=%0d data=%h len=%0d lk=%b busy=%b full=%b, expected 0 0 00 0 0 1 0",
                  name_we, name_addr, name_data, length, locked, busy, full);
      else n_pass++;
      Reset = 1'b0;
      step();
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if ({name_we, name_addr, name_data, busy} !== {1'b1, 3'(i), 7'h00, 1'b1})
            $display("FAIL reset_clear_%0d: got we=%b addr=%0d data=%h busy=%b, expected we=1 addr=%0d data=00 busy=1",
                     i, name_we, name_addr, name_data, busy, i);
         else n_pass++;
         step();
      end
      n_checks++;
      if ({busy, name_we, length, locked, full} !== {1'b0, 1'b0, 4'd0, 1'b0, 1'b0})
         $display("FAIL reset_idle: got busy=%b we=%b len=%0d lk=%b full=%b, expected 0 0 0 0 0",
                  busy, name_we, length, locked, full);
      else n_pass++;
   endtask

   task automatic test_typing();
      logic [7:0] kcs   [3] = '{8'h04, 8'h05, 8'h2C};
      logic [6:0] chars [3] = '{7'h61, 7'h62, 7'h20};
      for (int i = 0; i < 3; i++) begin
         keycode = kcs[i];
         step();
         n_checks++;
         if ({name_we, name_addr, name_data, length} !== {1'b1, 3'(i), chars[i], 4'(i + 1)})
            $display("FAIL typing_%0d: got we=%b addr=%0d data=%h len=%0d, expected we=1 addr=%0d data=%h len=%0d",
                     i, name_we, name_addr, name_data, length, i, chars[i], i + 1);
         else n_pass++;
         keycode = 8'h00;
         step();
         n_checks++;
         if (name_we !== 1'b0)
            $display("FAIL typing_gap_%0d: got we=%b expected 0", i, name_we);
         else n_pass++;
      end
   endtask

   task automatic test_backspace();
      keycode = 8'h2A;
      step();
      n_checks++;
      if ({name_we, name_addr, name_data, length} !== {1'b1, 3'd2, 7'h00, 4'd2})
         $display("FAIL backspace: got we=%b addr=%0d data=%h len=%0d, expected we=1 addr=2 data=00 len=2",
                  name_we, name_addr, name_data, length);
      else n_pass++;
      keycode = 8'h00;
      step();
   endtask

   task automatic test_lock_escape();
      logic [7:0] ign [2] = '{8'h04, 8'h2A};
      keycode = 8'h28;
      step();
      n_checks++;
      if ({name_we, locked, length, busy} !== {1'b0, 1'b1, 4'd2, 1'b0})
         $display("FAIL lock_enter: got we=%b lk=%b len=%0d busy=%b, expected 0 1 2 0",
                  name_we, locked, length, busy);
      else n_pass++;
      keycode = 8'h00;
      step();
      for (int i = 0; i < 2; i++) begin
         keycode = ign[i];
         step();
         n_checks++;
         if ({name_we, length, locked} !== {1'b0, 4'd2, 1'b1})
            $display("FAIL locked_ignore_%0d: got we=%b len=%0d lk=%b, expected 0 2 1",
                     i, name_we, length, locked);
         else n_pass++;
         keycode = 8'h00;
         step();
      end
      keycode = 8'h29;
      step();
      n_checks++;
      if ({name_we, busy, locked} !== {1'b0, 1'b1, 1'b1})
         $display("FAIL locked_escape: got we=%b busy=%b lk=%b, expected 0 1 1", name_we, busy, locked);
      else n_pass++;
      keycode = 8'h00;
      step();
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if ({name_we, name_addr, name_data, busy, locked} !== {1'b1, 3'(i), 7'h00, 1'b1, 1'b1})
            $display("FAIL esc_clear_%0d: got we=%b addr=%0d data=%h busy=%b lk=%b, expected 1 %0d 00 1 1",
                     i, name_we, name_addr, name_data, busy, locked, i);
         else n_pass++;
         step();
      end
      n_checks++;
      if ({busy, locked, length, name_we} !== {1'b0, 1'b0, 4'd0, 1'b0})
         $display("FAIL esc_done: got busy=%b lk=%b len=%0d we=%b, expected 0 0 0 0",
                  busy, locked, length, name_we);
      else n_pass++;
   endtask

   task automatic test_empty_ignored();
      logic [7:0] kcs [4] = '{8'h2A, 8'h28, 8'h2D, 8'h01};
      for (int i = 0; i < 4; i++) begin
         keycode = kcs[i];
         step();
         n_checks++;
         if ({name_we, length, locked, busy} !== {1'b0, 4'd0, 1'b0, 1'b0})
            $display("FAIL empty_ignore_%0d: got we=%b len=%0d lk=%b busy=%b, expected 0 0 0 0",
                     i, name_we, length, locked, busy);
         else n_pass++;
         keycode = 8'h00;
         step();
      end
   endtask

   task automatic test_fill();
      logic [7:0] kcs   [9] = '{8'h04, 8'h1E, 8'h1D, 8'h27, 8'h26, 8'h2C, 8'h05, 8'h1A, 8'h06};
      logic [6:0] chars [8] = '{7'h61, 7'h31, 7'h7A, 7'h30, 7'h39, 7'h20, 7'h62, 7'h77};
      int n_writes = 0;
      for (int i = 0; i < 9; i++) begin
         keycode = kcs[i];
         step();
         n_writes += int'(name_we);
         n_checks++;
         if (i < 8) begin
            if ({name_we, name_addr, name_data, length} !== {1'b1, 3'(i), chars[i], 4'(i + 1)})
               $display("FAIL fill_%0d: got we=%b addr=%0d data=%h len=%0d, expected we=1 addr=%0d data=%h len=%0d",
                        i, name_we, name_addr, name_data, length, i, chars[i], i + 1);
            else n_pass++;
         end else begin
            if ({name_we, length, full} !== {1'b0, 4'd8, 1'b1})
               $display("FAIL fill_ninth: got we=%b len=%0d full=%b, expected 0 8 1", name_we, length, full);
            else n_pass++;
         end
         if (i == 2) begin
            for (int h = 0; h < 4; h++) begin
               step();
               n_writes += int'(name_we);
            end
         end
         keycode = 8'h00;
         step();
         n_writes += int'(name_we);
      end
      n_checks++;
      if (n_writes !== 8)
         $display("FAIL fill_write_count: got %0d expected 8", n_writes);
      else n_pass++;
      n_checks++;
      if ({length, full} !== {4'd8, 1'b1})
         $display("FAIL fill_full: got len=%0d full=%b, expected 8 1", length, full);
      else n_pass++;
   endtask

   task automatic test_backspace_full();
      keycode = 8'h2A;
      step();
      n_checks++;
      if ({name_we, name_addr, name_data, length, full} !== {1'b1, 3'd7, 7'h00, 4'd7, 1'b0})
         $display("FAIL backspace_full: got we=%b addr=%0d data=%h len=%0d full=%b, expected 1 7 00 7 0",
                  name_we, name_addr, name_data, length, full);
      else n_pass++;
      keycode = 8'h00;
      step();
   endtask

   task automatic test_reset_mid_clear();
      keycode = 8'h29;
      step();
      keycode = 8'h00;
      step();
      keycode = 8'h04;
      step();
      n_checks++;
      if ({name_we, name_addr, name_data} !== {1'b1, 3'd1, 7'h00})
         $display("FAIL clear_press_ignored: got we=%b addr=%0d data=%h, expected 1 1 00",
                  name_we, name_addr, name_data);
      else n_pass++;
      keycode = 8'h00;
      step(); step(); step();
      n_checks++;
      if ({name_we, name_addr, busy} !== {1'b1, 3'd4, 1'b1})
         $display("FAIL clear_at4: got we=%b addr=%0d busy=%b, expected 1 4 1", name_we, name_addr, busy);
      else n_pass++;
      Reset = 1'b1;
      step();
      n_checks++;
      if ({name_we, name_addr, name_data, busy, length, locked} !== {1'b0, 3'd0, 7'h00, 1'b1, 4'd0, 1'b0})
         $display("FAIL mid_reset: got we=%b addr=%0d data=%h busy=%b len=%0d lk=%b, expected 0 0 00 1 0 0",
                  name_we, name_addr, name_data, busy, length, locked);
      else n_pass++;
      Reset = 1'b0;
      step();
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if ({name_we, name_addr, name_data, busy} !== {1'b1, 3'(i), 7'h00, 1'b1})
            $display("FAIL restart_clear_%0d: got we=%b addr=%0d data=%h busy=%b, expected 1 %0d 00 1",
                     i, name_we, name_addr, name_data, busy, i);
         else n_pass++;
         if (i == 2) keycode = 8'h05;
         step();
      end
      n_checks++;
      if ({busy, name_we, length} !== {1'b0, 1'b0, 4'd0})
         $display("FAIL restart_idle: got busy=%b we=%b len=%0d, expected 0 0 0", busy, name_we, length);
      else n_pass++;
      step();
      n_checks++;
      if ({name_we, length} !== {1'b0, 4'd0})
         $display("FAIL held_through_clear: got we=%b len=%0d, expected 0 0", name_we, length);
      else n_pass++;
      keycode = 8'h00;
      step();
      keycode = 8'h05;
      step();
      n_checks++;
      if ({name_we, name_addr, name_data, length} !== {1'b1, 3'd0, 7'h62, 4'd1})
         $display("FAIL post_clear_press: got we=%b addr=%0d data=%h len=%0d, expected 1 0 62 1",
                  name_we, name_addr, name_data, length);
      else n_pass++;
      keycode = 8'h00;
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_typing();
      test_backspace();
      test_lock_escape();
      test_empty_ignored();
      test_fill();
      test_backspace_full();
      test_reset_mid_clear();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/name_entry_ctrl.md
# name_entry_ctrl

Keyboard-driven write sequencer for the 8-character team-name buffer in the text-drawing path. Converts USB HID keycodes into 7-bit ASCII and drives the buffer's write port (address, data, write enable), maintaining length, backspace, clear and lock state. On reset it runs an 8-cycle clear sequence so the buffer never depends on its own reset. The text renderer keeps sole use of the buffer's read port.

## Interface
Parameters:
- NAME_LEN, 8, buffer depth in characters; fixes name_addr at 3 bits and length at 4 bits.
- CLR_CHAR, 7'h00, character written by clear and backspace.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high.
- keycode  in  8  HID keycode, level; 8'h00 means no key.
- name_we  out  1  buffer write enable, one cycle per write.
- name_addr  out  3  buffer write address.
- name_data  out  7  ASCII character to write.
- length  out  4  characters entered, 0..8.
- full  out  1  length == 8.
- locked  out  1  name confirmed by Enter.
- busy  out  1  clear sequence in progress; key presses ignored.

## Operation
- Press detection: kc_prev registers keycode every cycle. press = (kc_prev == 0) && (keycode != 0). Held keys give one press; no auto-repeat. kc_prev updates in every state, including during Reset.
- Keycode map, all other codes ignored:
  - 0x04..0x1D → 0x61..0x7A ('a'..'z')
  - 0x1E..0x26 → 0x31..0x39
  - 0x27 → 0x30
  - 0x2C → 0x20
  - 0x2A = Backspace, 0x28 = Enter, 0x29 = Escape
- FSM states:
  - CLEAR:
    - clr_cnt steps 0..7, writing CLR_CHAR to address clr_cnt each cycle.
    - After the write to address 7: go to IDLE, with length = 0 and locked = 0.
    - busy = 1.
  - IDLE, on press:
    - Printable char with length < 8: write char at address length; length += 1.
    - Printable char with length == 8: ignored, no write.
    - Backspace with length > 0: write CLR_CHAR at address length-1; length -= 1.
    - Backspace with length == 0: ignored.
    - Enter with length > 0: go to LOCKED, locked = 1, no write.
    - Enter with length == 0: ignored.
    - Escape: go to CLEAR, clr_cnt = 0.
  - LOCKED:
    - Escape: go to CLEAR; locked stays 1 until the clear finishes.
    - All other presses ignored.
    - length is held.
- Arithmetic: length is 4-bit unsigned and saturates by rule (no write at 8, no decrement at 0). Addresses never wrap.

## Timing
- Reset (synchronous):
  - state = CLEAR, clr_cnt = 0, name_we = 0, name_addr = 0, name_data = 0.
  - length = 0, locked = 0, kc_prev = keycode.
  - busy = 1 while in reset and during the clear.
- Clear after reset: first write occurs in the first cycle after Reset deasserts. name_we is high for 8 consecutive cycles, addresses 0..7, data CLR_CHAR. IDLE (busy = 0) is reached in the cycle after address 7.
- Key latency: press seen in cycle N → name_we = 1 with the registered addr/data in cycle N+1. length, full and locked update in the same cycle N+1.
- name_we is never high for two consecutive cycles outside CLEAR.
- Presses during CLEAR are dropped, not queued. A key held from CLEAR into IDLE does not produce a press.
- Reset asserted mid-clear or mid-entry: the clear sequence restarts from address 0.
- Simultaneous events are not possible: there is one keycode input, so at most one press per cycle.
- All outputs are registered except busy and full, which are decoded from state and length.

## Test plan
- Reset release → name_we high 8 cycles, addr 0..7, data 0x00; then busy = 0, length = 0, locked = 0.
- Press 0x04, 0x05, 0x2C (each returning to 0x00 between presses) → writes (0, 0x61), (1, 0x62), (2, 0x20), each one cycle after its press; length = 3.
- Enter 9 letters, holding 0x1D for 5 cycles on one of them → exactly 8 writes, length = 8, full = 1. The ninth press and the held cycles produce no writes.
- At length = 3: Backspace → write (2, 0x00), length = 2. At length = 0: Backspace or Enter → no write, no state change.
- At length = 2: Enter → locked = 1. Then letter presses → no writes. Then Escape → 8-cycle clear, then locked = 0, length = 0.
- Assert Reset at clear address 4 → clear restarts from address 0. Press during clear → ignored.
